nibble_add_seq: RTL

- Multi-cycle sequencer that runs 8-bit ADD/SUB/ADC/SBB through one shared external 4-bit ripple adder slice, low nibble then high nibble.
- Sits between the ALU opcode decode and the 4-bit adder instance.
- Owns operand latching, B inversion for subtract, inter-nibble carry, the persistent carry flag and the result flags.

---
 rtl/nibble_add_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: 8-bit ADD/SUB/ADC/SBB sequenced through one shared external
// 4-bit adder slice, low nibble first, then high nibble.
// Optional build macro NIBBLE_ADD_SAT_EN: saturate the result on signed overflow.
module nibble_add_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       ready,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic [3:0] nib_a,
  output logic [3:0] nib_b,
  output logic       nib_cin,
  input  logic [3:0] nib_s,
  input  logic       nib_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;

  // Only the high nibbles are kept; the low nibbles go straight to the adder at accept.
  logic [3:0] r_a_hi;
  logic [3:0] r_bx_hi;

  logic [7:0] w_bx;
  logic       w_cin0;
  logic [7:0] w_raw;
  logic [7:0] w_res;
  logic       w_v;

  // Operand prep at accept: invert B for SUB/SBB, pick the low-nibble carry-in.
  always_comb begin
    w_bx   = b ^ {8{op[0]}};
    w_cin0 = op[1] ? flag_c : op[0];
  end

  // High-nibble result, signed overflow and optional saturation.
  always_comb begin
    w_raw = {nib_s, result[3:0]};
    w_v   = (r_a_hi[3] == r_bx_hi[3]) && (nib_s[3] != r_a_hi[3]);
`ifdef NIBBLE_ADD_SAT_EN
    w_res = w_raw;
    if (w_v) begin
      w_res = r_a_hi[3] ? 8'h80 : 8'h7F;
    end
`else
    w_res = w_raw;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_DONE;
      S_DONE:  w_next = start ? S_LO : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered outputs, operand latch and adder drive, all keyed off the next state.
  // nib_cin doubles as the inter-nibble carry latch while in HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready   <= 1'b1;
      done    <= 1'b0;
      result  <= 8'h00;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
      nib_a   <= 4'h0;
      nib_b   <= 4'h0;
      nib_cin <= 1'b0;
      r_a_hi  <= 4'h0;
      r_bx_hi <= 4'h0;
    end else begin
      ready   <= (w_next == S_IDLE) || (w_next == S_DONE);
      done    <= (w_next == S_DONE);
      nib_a   <= 4'h0;
      nib_b   <= 4'h0;
      nib_cin <= 1'b0;

      if (w_next == S_LO) begin
        r_a_hi  <= a[7:4];
        r_bx_hi <= w_bx[7:4];
        nib_a   <= a[3:0];
        nib_b   <= w_bx[3:0];
        nib_cin <= w_cin0;
      end

      if (r_state == S_LO) begin
        result[3:0] <= nib_s;
        nib_a       <= r_a_hi;
        nib_b       <= r_bx_hi;
        nib_cin     <= nib_cout;
      end

      if (r_state == S_HI) begin
        result <= w_res;
        flag_c <= nib_cout;
        flag_v <= w_v;
        flag_n <= w_res[7];
        flag_z <= (w_res == 8'h00);
      end
    end
  end

endmodule
